compressed_fetch_queue: RTL and testbench
=========================================

# compressed_fetch_queue

Prefetch queue between the instruction memory and the decompressor input register. It issues sequential word fetches ahead of the decompressor and buffers the returned compressed words with their PCs. On a redirect it flushes and discards stale in-flight responses, so the decompressor always sees an in-order stream of (PC, word) pairs from the current fetch path.

## Interface
Parameters:
- WIDTH, 32, word and address width
- DEPTH, 4, queue entries; power of two, 2..16
- PCADD, 32'b100, address increment per fetched word
- RESET_PC, 32'h0, first fetch address after reset

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- redirect  in  1  branch/jump taken; restart fetch at redirect_pc
- redirect_pc  in  WIDTH  new fetch address
- mem_req  out  1  fetch request valid
- mem_addr  out  WIDTH  fetch address
- mem_gnt  in  1  memory accepts request this cycle
- mem_rvalid  in  1  response valid; responses arrive in request order, ≥1 cycle after grant
- mem_rdata  in  WIDTH  response word
- out_valid  out  1  head entry valid
- out_instr  out  WIDTH  head compressed word
- out_pc  out  WIDTH  address of head word
- out_ready  in  1  decompressor consumes head this cycle

## Operation
- State: fetch_pc, resp_pc, FIFO (DEPTH×{pc,word}), count, outstanding, discard; counters are $clog2(DEPTH)+1 bits.
- Credit rule: mem_req = (count + outstanding < DEPTH) && !redirect. This guarantees every response has a slot.
- Grant (mem_req && mem_gnt): fetch_pc += PCADD (mod 2^WIDTH wrap); outstanding += 1.
- Response (mem_rvalid):
  - If discard > 0: discard -= 1 and outstanding -= 1; the word is dropped.
  - Otherwise: push {resp_pc, mem_rdata}, resp_pc += PCADD, outstanding -= 1.
- Pop: out_valid && out_ready advances the head pointer. Push and pop in the same cycle leave count unchanged.
- Redirect has priority over all other events in its cycle:
  - fetch_pc and resp_pc ← redirect_pc; FIFO emptied (count=0).
  - discard ← outstanding after this cycle's grant/response are accounted. The response arriving in the redirect cycle is dropped.
  - The same-cycle pop is ignored.
- mem_rvalid with outstanding=0 is a protocol error. Ignore it; a bench assertion flags it.

## Timing
- Reset (reset=0 at edge): fetch_pc=resp_pc=RESET_PC, count=outstanding=discard=0.
- Outputs during and after reset: mem_req=1 in the first cycle after reset release (credits free), mem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0.
- out_instr/out_pc are 0 whenever out_valid=0.
- Reset asserted mid-operation clears everything in one cycle. Memory is reset by the same signal, so no late responses arrive.
- mem_addr = fetch_pc, a registered output. mem_req is combinational from registered counters and redirect.
- Latency: response at edge N makes out_valid=1 from edge N+1 (registered FIFO path).
- Full: count+outstanding=DEPTH holds mem_req=0. A pop in cycle N re-enables mem_req in cycle N+1.
- First valid after redirect: ≥2 cycles after the redirect edge (request, then response, then register).

## Configuration
- FETCHQ_BYPASS_EN defined: when count=0, mem_rvalid=1, discard=0 and !redirect, the response is driven onto out_valid/out_instr/out_pc in the same cycle (combinational).
  - If out_ready=1, the word is not written into the FIFO.
  - Otherwise it is pushed normally.
  - Latency is 0 cycles from response to output.
- Undefined: all responses pass through the FIFO; out_* are driven only from FIFO registers; latency is 1 cycle.

## Test plan
- Reset release, mem_gnt=1, 1-cycle memory returning addr^32'hA5A5A5A5, out_ready=1 -> out_pc sequence 0,4,8,C with matching out_instr; no gaps after fill.
- out_ready=0, DEPTH=4 -> exactly 4 grants, then mem_req=0 with count=4; one pop -> one new grant in the following cycle.
- 3 requests outstanding with 3-cycle memory, redirect to 32'h100 -> 3 responses dropped; first out_valid has out_pc=0x100; no stale words appear.
- Redirect in the same cycle as mem_rvalid and a pop -> the response is dropped, the FIFO is empty next cycle, and discard equals the remaining outstanding count.
- fetch_pc=32'hFFFFFFFC -> next mem_addr=0 and out_pc wraps to 0.
- With FETCHQ_BYPASS_EN, empty queue, out_ready=1 -> out_valid in the same cycle as mem_rvalid and count stays 0. Without the macro -> out_valid one cycle later.

Source files
------------

// File: rtl/compressed_fetch_queue_if.sv
// Bus bundle for compressed_fetch_queue: memory fetch port and decompressor output port.
// master = the fetch queue, slave = memory/decompressor side.
interface compressed_fetch_queue_if #(
  parameter int WIDTH = 32
);
  logic             mem_req;
  logic [WIDTH-1:0] mem_addr;
  logic             mem_gnt;
  logic             mem_rvalid;
  logic [WIDTH-1:0] mem_rdata;
  logic             out_valid;
  logic [WIDTH-1:0] out_instr;
  logic [WIDTH-1:0] out_pc;
  logic             out_ready;

  modport master (
    output mem_req, mem_addr, out_valid, out_instr, out_pc,
    input  mem_gnt, mem_rvalid, mem_rdata, out_ready
  );

  modport slave (
    input  mem_req, mem_addr, out_valid, out_instr, out_pc,
    output mem_gnt, mem_rvalid, mem_rdata, out_ready
  );
endinterface

// File: rtl/compressed_fetch_queue.sv
// Credit-based instruction prefetch queue with redirect flush and stale-response discard.
// Optional same-cycle response bypass to the output is enabled by defining FETCHQ_BYPASS_EN.
module compressed_fetch_queue #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] PCADD    = WIDTH'(32'b100),
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   redirect,
  input  logic [WIDTH-1:0]       redirect_pc,
  compressed_fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] resp_pc;
  logic [WIDTH-1:0] fifo_pc   [DEPTH];
  logic [WIDTH-1:0] fifo_word [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [CW-1:0]    count;
  logic [CW-1:0]    outstanding;
  logic [CW-1:0]    discard;
  logic [CW-1:0]    outstanding_next;
  logic [CW:0]      credits_used;
  logic             grant;
  logic             rsp;
  logic             keep;
  logic             bypass;
  logic             push;
  logic             pop;

  // Every issued request reserves a FIFO slot, so a response can never overflow the queue.
  assign credits_used     = {1'b0, count} + {1'b0, outstanding};
  assign bus.mem_req      = (credits_used < (CW+1)'(DEPTH)) && !redirect;
  assign bus.mem_addr     = fetch_pc;
  assign grant            = bus.mem_req && bus.mem_gnt;
  assign rsp              = bus.mem_rvalid && (outstanding != '0);
  assign keep             = rsp && (discard == '0) && !redirect;
  assign outstanding_next = outstanding + CW'(grant) - CW'(rsp);

`ifdef FETCHQ_BYPASS_EN
  assign bypass = keep && (count == '0);
`else
  assign bypass = 1'b0;
`endif

  assign push = keep && !(bypass && bus.out_ready);
  assign pop  = (count != '0) && bus.out_ready && !redirect;

  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_instr = '0;
    bus.out_pc    = '0;
    if (count != '0) begin
      bus.out_valid = 1'b1;
      bus.out_instr = fifo_word[head];
      bus.out_pc    = fifo_pc[head];
    end else if (bypass) begin
      bus.out_valid = 1'b1;
      bus.out_instr = bus.mem_rdata;
      bus.out_pc    = resp_pc;
    end
  end

  // A redirect keeps every request still in flight as a discard credit so stale words are dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        discard  <= outstanding_next;
      end else begin
        if (grant)
          fetch_pc <= fetch_pc + PCADD;
        if (keep)
          resp_pc <= resp_pc + PCADD;
        if (rsp && (discard != '0))
          discard <= discard - CW'(1);
        if (push)
          tail <= tail + AW'(1);
        if (pop)
          head <= head + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[tail]   <= resp_pc;
      fifo_word[tail] <= bus.mem_rdata;
    end
  end
endmodule

// File: tb/tb_compressed_fetch_queue.sv
// Self-checking bench for compressed_fetch_queue: directed vector table plus randomized run
// against an in-order (pc, word) stream model with an epoch-tagged memory model.
module tb_compressed_fetch_queue;
  localparam int DEPTH = 4;
`ifdef FETCHQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  compressed_fetch_queue_if #(.WIDTH(32)) bus();

  compressed_fetch_queue #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        gnt, rv, ready, redir;
    logic [31:0] rpc, rdata;
    logic        req;
    logic [31:0] addr;
    logic        ov;
    logic [31:0] pc, instr;
  } vec_t;

  typedef struct { logic [31:0] addr; int epoch; int due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] word; } ent_t;

  vec_t        tbl [28];
  pend_t       pend_q [$];
  ent_t        mq [$];
  int          epoch = 0;
  logic [31:0] next_fetch = '0;

  function automatic logic [31:0] memWord(logic [31:0] a);
    return a ^ 32'hA5A5A5A5;
  endfunction

  function automatic vec_t row(logic gnt, logic rv, logic [31:0] rdata, logic ready, logic redir,
                               logic [31:0] rpc, logic req, logic [31:0] addr, logic ov, logic [31:0] pc);
    vec_t v;
    v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.ready = ready; v.redir = redir; v.rpc = rpc;
    v.req = req; v.addr = addr; v.ov = ov;
    v.pc    = ov ? pc : 32'h0;
    v.instr = ov ? memWord(pc) : 32'h0;
    return v;
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(logic gnt, logic rv, logic [31:0] rdata, logic ready,
                               logic redir, logic [31:0] rpc);
    @(negedge clk);
    reset          = 1'b1;
    bus.mem_gnt    = gnt;
    bus.mem_rvalid = rv;
    bus.mem_rdata  = rdata;
    bus.out_ready  = ready;
    redirect       = redir;
    redirect_pc    = rpc;
  endtask

  task automatic doReset(string tag);
    @(negedge clk);
    reset = 1'b0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.out_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    @(posedge clk);
    #2;
    checkOutput({tag, "_req"},   {31'b0, bus.mem_req},   32'h1);
    checkOutput({tag, "_addr"},  bus.mem_addr,           32'h0);
    checkOutput({tag, "_valid"}, {31'b0, bus.out_valid}, 32'h0);
    checkOutput({tag, "_instr"}, bus.out_instr,          32'h0);
    checkOutput({tag, "_pc"},    bus.out_pc,             32'h0);
    pend_q.delete();
    mq.delete();
    epoch++;
    next_fetch = 32'h0;
  endtask

  // One cycle per iteration: drive, compare against the stream model, then advance the model.
  task automatic runModel(int n, bit directed);
    logic        gnt, rv, ready, redir, exp_req, exp_valid, byp, consume;
    logic [31:0] rdata, rpc, exp_pc, exp_instr, first_pc;
    int          lat;
    bit          seen_redirect, seen_first;
    ent_t        e;
    pend_t       r;
    first_pc = 32'hDEADBEEF;
    seen_redirect = 0;
    seen_first = 0;
    for (int i = 0; i < n; i++) begin
      cyc++;
      if (directed) begin
        gnt = 1'b1; ready = 1'b1; redir = (i == 3); rpc = 32'h100; lat = 3;
        rv = (pend_q.size() > 0) && (pend_q[0].due <= cyc);
      end else begin
        gnt   = ($urandom_range(0, 3) != 0);
        ready = ($urandom_range(0, 2) != 0);
        redir = ($urandom_range(0, 24) == 0);
        rpc   = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 : 32'($urandom_range(0, 1023)) << 2;
        lat   = $urandom_range(1, 3);
        rv    = (pend_q.size() > 0) && (pend_q[0].due <= cyc) && ($urandom_range(0, 3) != 0);
      end
      rdata = rv ? memWord(pend_q[0].addr) : $urandom;
      assert (!(rv && pend_q.size() == 0));
      applyStimulus(gnt, rv, rdata, ready, redir, rpc);
      #2;
      exp_req = ((mq.size() + pend_q.size()) < DEPTH) && !redir;
      byp = BYP && (mq.size() == 0) && rv && (pend_q[0].epoch == epoch) && !redir;
      exp_valid = (mq.size() > 0) || byp;
      exp_pc = 32'h0;
      exp_instr = 32'h0;
      if (mq.size() > 0) begin
        exp_pc = mq[0].pc; exp_instr = mq[0].word;
      end else if (byp) begin
        exp_pc = pend_q[0].addr; exp_instr = memWord(pend_q[0].addr);
      end
      checkOutput("m_req",   {31'b0, bus.mem_req},   {31'b0, exp_req});
      checkOutput("m_addr",  bus.mem_addr,           next_fetch);
      checkOutput("m_valid", {31'b0, bus.out_valid}, {31'b0, exp_valid});
      checkOutput("m_pc",    bus.out_pc,             exp_pc);
      checkOutput("m_instr", bus.out_instr,          exp_instr);

      consume = exp_valid && ready && !redir;
      if (directed && seen_redirect && consume && !seen_first) begin
        first_pc = exp_pc;
        seen_first = 1;
      end
      if (redir) seen_redirect = 1;
      if (consume && mq.size() > 0) void'(mq.pop_front());
      if (rv) begin
        r = pend_q.pop_front();
        if (r.epoch == epoch && !redir && !(byp && ready)) begin
          e.pc = r.addr; e.word = memWord(r.addr);
          mq.push_back(e);
        end
      end
      if (exp_req && gnt) begin
        r.addr = next_fetch; r.epoch = epoch; r.due = cyc + lat;
        pend_q.push_back(r);
        next_fetch = next_fetch + 32'd4;
      end
      if (redir) begin
        mq.delete();
        epoch++;
        next_fetch = rpc;
      end
    end
    if (directed) checkOutput("first_pc_after_redirect", first_pc, 32'h100);
  endtask

  initial begin
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.out_ready = 1'b0;

    //            gnt rv  rdata                    rdy redir rpc            req addr          ov    pc
    tbl[0]  = row(1, 0, 32'h0,                    0, 0, 32'h0,          1, 32'h0,         1'b0, 32'h0);
    tbl[1]  = row(1, 1, memWord(32'h0),           0, 0, 32'h0,          1, 32'h4,         BYP,  32'h0);
    tbl[2]  = row(1, 1, memWord(32'h4),           0, 0, 32'h0,          1, 32'h8,         1'b1, 32'h0);
    tbl[3]  = row(1, 1, memWord(32'h8),           0, 0, 32'h0,          1, 32'hC,         1'b1, 32'h0);
    tbl[4]  = row(1, 1, memWord(32'hC),           0, 0, 32'h0,          0, 32'h10,        1'b1, 32'h0);
    tbl[5]  = row(1, 0, 32'h0,                    0, 0, 32'h0,          0, 32'h10,        1'b1, 32'h0);
    tbl[6]  = row(1, 0, 32'h0,                    1, 0, 32'h0,          0, 32'h10,        1'b1, 32'h0);
    tbl[7]  = row(1, 0, 32'h0,                    0, 0, 32'h0,          1, 32'h10,        1'b1, 32'h4);
    tbl[8]  = row(1, 1, memWord(32'h10),          0, 0, 32'h0,          0, 32'h14,        1'b1, 32'h4);
    tbl[9]  = row(0, 0, 32'h0,                    1, 0, 32'h0,          0, 32'h14,        1'b1, 32'h4);
    tbl[10] = row(0, 0, 32'h0,                    1, 0, 32'h0,          1, 32'h14,        1'b1, 32'h8);
    tbl[11] = row(0, 0, 32'h0,                    1, 0, 32'h0,          1, 32'h14,        1'b1, 32'hC);
    tbl[12] = row(0, 0, 32'h0,                    1, 0, 32'h0,          1, 32'h14,        1'b1, 32'h10);
    tbl[13] = row(0, 0, 32'h0,                    1, 0, 32'h0,          1, 32'h14,        1'b0, 32'h0);
    tbl[14] = row(1, 0, 32'h0,                    1, 0, 32'h0,          1, 32'h14,        1'b0, 32'h0);
    tbl[15] = row(1, 0, 32'h0,                    1, 0, 32'h0,          1, 32'h18,        1'b0, 32'h0);
    tbl[16] = row(1, 1, memWord(32'h14),          0, 0, 32'h0,          1, 32'h1C,        BYP,  32'h14);
    tbl[17] = row(1, 1, memWord(32'h18),          1, 1, 32'h100,        0, 32'h20,        1'b1, 32'h14);
    tbl[18] = row(0, 1, memWord(32'h1C),          1, 0, 32'h0,          1, 32'h100,       1'b0, 32'h0);
    tbl[19] = row(1, 0, 32'h0,                    1, 0, 32'h0,          1, 32'h100,       1'b0, 32'h0);
    tbl[20] = row(0, 1, memWord(32'h100),         0, 0, 32'h0,          1, 32'h104,       BYP,  32'h100);
    tbl[21] = row(0, 0, 32'h0,                    1, 0, 32'h0,          1, 32'h104,       1'b1, 32'h100);
    tbl[22] = row(0, 0, 32'h0,                    0, 1, 32'hFFFFFFFC,   0, 32'h104,       1'b0, 32'h0);
    tbl[23] = row(1, 0, 32'h0,                    0, 0, 32'h0,          1, 32'hFFFFFFFC,  1'b0, 32'h0);
    tbl[24] = row(1, 1, memWord(32'hFFFFFFFC),    1, 0, 32'h0,          1, 32'h0,         BYP,  32'hFFFFFFFC);
    tbl[25] = row(0, 1, memWord(32'h0),           1, 0, 32'h0,          1, 32'h4,         1'b1, BYP ? 32'h0 : 32'hFFFFFFFC);
    tbl[26] = row(0, 0, 32'h0,                    1, 0, 32'h0,          1, 32'h4,         !BYP, 32'h0);
    tbl[27] = row(0, 0, 32'h0,                    0, 0, 32'h0,          1, 32'h4,         1'b0, 32'h0);

    doReset("reset");
    for (int i = 0; i < 28; i++) begin
      cyc++;
      applyStimulus(tbl[i].gnt, tbl[i].rv, tbl[i].rdata, tbl[i].ready, tbl[i].redir, tbl[i].rpc);
      #2;
      checkOutput($sformatf("row%0d_req", i),   {31'b0, bus.mem_req},   {31'b0, tbl[i].req});
      checkOutput($sformatf("row%0d_addr", i),  bus.mem_addr,           tbl[i].addr);
      checkOutput($sformatf("row%0d_valid", i), {31'b0, bus.out_valid}, {31'b0, tbl[i].ov});
      checkOutput($sformatf("row%0d_pc", i),    bus.out_pc,             tbl[i].pc);
      checkOutput($sformatf("row%0d_instr", i), bus.out_instr,          tbl[i].instr);
    end

    doReset("reset_directed");
    runModel(16, 1'b1);
    doReset("reset_random");
    runModel(600, 1'b0);
    doReset("reset_midop");
    runModel(600, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
